// File: rtl/ddr4_v2_2_20_mc_ecc_merge_enc.sv
// Write-path ECC stage: aligns write bursts with RMW read-back data, byte-merges,
// SECDED-encodes each beat and optionally flips one payload bit for ECC testing.
module ddr4_v2_2_20_mc_ecc_merge_enc #(
  parameter int TCQ           = 100,
  parameter int DATA_WIDTH    = 64,
  parameter int ECC_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH = 72,
  parameter int nCK_PER_CLK   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wr_data_en,
  input  logic                                     wr_rmw,
  input  logic [2*nCK_PER_CLK*PAYLOAD_WIDTH-1:0]   wr_data,
  input  logic [2*nCK_PER_CLK*DATA_WIDTH/8-1:0]    wr_data_mask,
  input  logic [2*nCK_PER_CLK-1:0]                 raw_not_ecc,
  input  logic [2*nCK_PER_CLK*DATA_WIDTH-1:0]      rd_merge_data,
  input  logic                                     inj_arm,
  input  logic [2:0]                               inj_beat,
  input  logic [6:0]                               inj_bit,
  output logic                                     enc_wr_data_en,
  output logic [2*nCK_PER_CLK*PAYLOAD_WIDTH-1:0]   enc_wr_data,
  output logic                                     inj_pending,
  output logic [15:0]                              merge_cnt
);

  localparam int NB    = 2*nCK_PER_CLK;
  localparam int NBYTE = DATA_WIDTH/8;
  localparam int UW    = PAYLOAD_WIDTH - DATA_WIDTH;

  // TCQ only shapes simulation delay in older flows; the flops here are zero-delay.
  if (DATA_WIDTH != 64 || ECC_WIDTH != 8 || PAYLOAD_WIDTH != DATA_WIDTH + ECC_WIDTH ||
      TCQ < 0) begin : g_bad_params
    $error("ddr4_v2_2_20_mc_ecc_merge_enc: unsupported parameter set");
  end

  // Hsiao columns: all weight-3 codes ascending, then the smallest weight-5 codes.
  function automatic logic [DATA_WIDTH*ECC_WIDTH-1:0] gen_h();
    logic [DATA_WIDTH*ECC_WIDTH-1:0] h;
    int n;
    int w;
    h = '0;
    n = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < (1 << ECC_WIDTH); v++) begin
        w = 0;
        for (int i = 0; i < ECC_WIDTH; i++) begin
          if (v[i]) w++;
        end
        if (n < DATA_WIDTH && w == ((pass == 0) ? 3 : 5)) begin
          h[n*ECC_WIDTH +: ECC_WIDTH] = v[ECC_WIDTH-1:0];
          n++;
        end
      end
    end
    return h;
  endfunction

  localparam logic [DATA_WIDTH*ECC_WIDTH-1:0] H_COLS = gen_h();

  function automatic logic [ECC_WIDTH-1:0] calc_ecc(input logic [DATA_WIDTH-1:0] d);
    logic [ECC_WIDTH-1:0] e;
    e = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      for (int k = 0; k < ECC_WIDTH; k++) begin
        e[k] = e[k] ^ (d[j] & H_COLS[j*ECC_WIDTH + k]);
      end
    end
    return e;
  endfunction

  // Valid-only handshake: wr_data_en qualifies every input for exactly one cycle and
  // there is no ready; enc_wr_data_en qualifies enc_wr_data the same way downstream.
  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_rmw_q, s1_rmw_d;
  logic [NB*PAYLOAD_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic [NB*NBYTE-1:0]          s1_mask_q, s1_mask_d;
  logic [NB-1:0]                s1_raw_q, s1_raw_d;

  logic                         s2_valid_q, s2_valid_d;
  logic [NB*DATA_WIDTH-1:0]     s2_data_q, s2_data_d;
  logic [NB*UW-1:0]             s2_upper_q, s2_upper_d;
  logic [NB-1:0]                s2_raw_q, s2_raw_d;

  logic                         enc_valid_q, enc_valid_d;
  logic [NB*PAYLOAD_WIDTH-1:0]  enc_data_q, enc_data_d;

  logic                         inj_pending_q, inj_pending_d;
  logic [2:0]                   inj_beat_q, inj_beat_d;
  logic [6:0]                   inj_bit_q, inj_bit_d;
  logic [15:0]                  merge_cnt_q, merge_cnt_d;

  logic                         inj_consume;
  logic [PAYLOAD_WIDTH-1:0]     beat_w;

  always_comb begin
    s1_valid_d = wr_data_en;
    s1_rmw_d   = wr_rmw;
    s1_data_d  = wr_data;
    s1_mask_d  = wr_data_mask;
    s1_raw_d   = raw_not_ecc;
  end

  // Old data only replaces masked bytes on RMW bursts; full writes ignore the mask.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_raw_d   = s1_raw_q;
    s2_data_d  = '0;
    s2_upper_d = '0;
    for (int h = 0; h < NB; h++) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (s1_rmw_q && s1_mask_q[h*NBYTE + b])
          s2_data_d[h*DATA_WIDTH + b*8 +: 8] = rd_merge_data[h*DATA_WIDTH + b*8 +: 8];
        else
          s2_data_d[h*DATA_WIDTH + b*8 +: 8] = s1_data_q[h*PAYLOAD_WIDTH + b*8 +: 8];
      end
      s2_upper_d[h*UW +: UW] = s1_data_q[h*PAYLOAD_WIDTH + DATA_WIDTH +: UW];
    end
  end

  always_comb begin
    merge_cnt_d = merge_cnt_q;
    if (s1_valid_q && s1_rmw_q && merge_cnt_q != 16'hFFFF)
      merge_cnt_d = merge_cnt_q + 16'd1;
  end

  // The flip uses the selection latched before this edge, so a same-cycle re-arm
  // only affects the next encoded burst.
  always_comb begin
    inj_consume   = inj_pending_q && s2_valid_q;
    inj_pending_d = inj_arm || (inj_pending_q && !inj_consume);
    inj_beat_d    = inj_arm ? inj_beat : inj_beat_q;
    inj_bit_d     = inj_arm ? inj_bit  : inj_bit_q;
  end

  always_comb begin
    enc_valid_d = s2_valid_q;
    enc_data_d  = enc_data_q;
    beat_w      = '0;
    if (s2_valid_q) begin
      for (int h = 0; h < NB; h++) begin
        if (s2_raw_q[h])
          beat_w = {s2_upper_q[h*UW +: UW], s2_data_q[h*DATA_WIDTH +: DATA_WIDTH]};
        else
          beat_w = {calc_ecc(s2_data_q[h*DATA_WIDTH +: DATA_WIDTH]),
                    s2_data_q[h*DATA_WIDTH +: DATA_WIDTH]};
        for (int b = 0; b < PAYLOAD_WIDTH; b++) begin
          if (inj_consume && int'(inj_beat_q) == h && int'(inj_bit_q) == b)
            beat_w[b] = ~beat_w[b];
        end
        enc_data_d[h*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = beat_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_rmw_q      <= 1'b0;
      s1_data_q     <= '0;
      s1_mask_q     <= '0;
      s1_raw_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_data_q     <= '0;
      s2_upper_q    <= '0;
      s2_raw_q      <= '0;
      enc_valid_q   <= 1'b0;
      enc_data_q    <= '0;
      inj_pending_q <= 1'b0;
      inj_beat_q    <= '0;
      inj_bit_q     <= '0;
      merge_cnt_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_rmw_q      <= s1_rmw_d;
      s1_data_q     <= s1_data_d;
      s1_mask_q     <= s1_mask_d;
      s1_raw_q      <= s1_raw_d;
      s2_valid_q    <= s2_valid_d;
      s2_data_q     <= s2_data_d;
      s2_upper_q    <= s2_upper_d;
      s2_raw_q      <= s2_raw_d;
      enc_valid_q   <= enc_valid_d;
      enc_data_q    <= enc_data_d;
      inj_pending_q <= inj_pending_d;
      inj_beat_q    <= inj_beat_d;
      inj_bit_q     <= inj_bit_d;
      merge_cnt_q   <= merge_cnt_d;
    end
  end

  assign enc_wr_data_en = enc_valid_q;
  assign enc_wr_data    = enc_data_q;
  assign inj_pending    = inj_pending_q;
  assign merge_cnt      = merge_cnt_q;

endmodule

// File: tb/tb_ddr4_v2_2_20_mc_ecc_merge_enc.sv
// Directed bench for the ECC merge/encode stage: vector table plus hand-written
// injection, reset and counter-saturation sequences.
module tb_ddr4_v2_2_20_mc_ecc_merge_enc;

  logic         clk;
  logic         rst_n;
  logic         wr_data_en;
  logic         wr_rmw;
  logic [575:0] wr_data;
  logic [63:0]  wr_data_mask;
  logic [7:0]   raw_not_ecc;
  logic [511:0] rd_merge_data;
  logic         inj_arm;
  logic [2:0]   inj_beat;
  logic [6:0]   inj_bit;
  logic         enc_wr_data_en;
  logic [575:0] enc_wr_data;
  logic         inj_pending;
  logic [15:0]  merge_cnt;

  ddr4_v2_2_20_mc_ecc_merge_enc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data_en     (wr_data_en),
    .wr_rmw         (wr_rmw),
    .wr_data        (wr_data),
    .wr_data_mask   (wr_data_mask),
    .raw_not_ecc    (raw_not_ecc),
    .rd_merge_data  (rd_merge_data),
    .inj_arm        (inj_arm),
    .inj_beat       (inj_beat),
    .inj_bit        (inj_bit),
    .enc_wr_data_en (enc_wr_data_en),
    .enc_wr_data    (enc_wr_data),
    .inj_pending    (inj_pending),
    .merge_cnt      (merge_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string        name;
    logic         rmw;
    logic [7:0]   raw;
    logic [7:0]   mask;
    logic [71:0]  wr_b0;
    logic [71:0]  wr_rest;
    logic [63:0]  rd;
    logic [71:0]  exp_b0;
    logic [71:0]  exp_rest;
    logic         full;
  } vec_t;

  vec_t         vecs[13];
  int           n_total;
  int           n_bad;
  logic [15:0]  exp_mc;
  logic [575:0] exp_bus;
  logic [575:0] cmp_mask;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_data_en    = 1'b0;
    wr_rmw        = 1'b0;
    wr_data       = '0;
    wr_data_mask  = '0;
    raw_not_ecc   = '0;
    rd_merge_data = '0;
    inj_arm       = 1'b0;
    inj_beat      = '0;
    inj_bit       = '0;
  endtask

  task automatic run_vec(input vec_t v);
    // cycle T: present the burst
    wr_data_en   = 1'b1;
    wr_rmw       = v.rmw;
    raw_not_ecc  = v.raw;
    wr_data_mask = {8{v.mask}};
    for (int h = 0; h < 8; h++) begin
      wr_data[h*72 +: 72] = (h == 0) ? v.wr_b0 : v.wr_rest;
      exp_bus[h*72 +: 72] = (h == 0) ? v.exp_b0 : v.exp_rest;
      cmp_mask[h*72 +: 72] = v.full ? {72{1'b1}} : {8'h00, {64{1'b1}}};
    end
    tick();
    // cycle T+1: old data arrives from the read buffer
    wr_data_en    = 1'b0;
    wr_rmw        = 1'b0;
    wr_data       = '0;
    wr_data_mask  = '0;
    raw_not_ecc   = '0;
    rd_merge_data = {8{v.rd}};
    tick();
    rd_merge_data = '0;
    chk({v.name, "_en_early"}, 576'(enc_wr_data_en), 576'(0));
    tick();
    chk({v.name, "_en"}, 576'(enc_wr_data_en), 576'(1));
    chk({v.name, "_data"}, enc_wr_data & cmp_mask, exp_bus & cmp_mask);
    if (v.rmw) exp_mc = exp_mc + 16'd1;
    chk({v.name, "_merge_cnt"}, 576'(merge_cnt), 576'(exp_mc));
    tick();
    chk({v.name, "_en_drop"}, 576'(enc_wr_data_en), 576'(0));
    chk({v.name, "_hold"}, enc_wr_data & cmp_mask, exp_bus & cmp_mask);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_mc  = '0;
    exp_bus = '0;
    cmp_mask = '0;

    vecs[0]  = '{"zero",     1'b0, 8'h00, 8'h00, 72'h0, 72'h0, 64'h0,
                 72'h0, 72'h0, 1'b1};
    vecs[1]  = '{"bit0",     1'b0, 8'h00, 8'h00, 72'h1, 72'h0, 64'h0,
                 72'h07_0000000000000001, 72'h0, 1'b1};
    vecs[2]  = '{"bit4",     1'b0, 8'h00, 8'h00, 72'h10, 72'h0, 64'h0,
                 72'h13_0000000000000010, 72'h0, 1'b1};
    vecs[3]  = '{"bits01",   1'b0, 8'h00, 8'h00, 72'h3, 72'h0, 64'h0,
                 72'h0C_0000000000000003, 72'h0, 1'b1};
    vecs[4]  = '{"byte0",    1'b0, 8'h00, 8'h00, 72'hFF, 72'h3FF, 64'h0,
                 72'h06_00000000000000FF, 72'h00_00000000000003FF, 1'b1};
    vecs[5]  = '{"bits79",   1'b0, 8'h00, 8'h00, 72'h280, 72'h200, 64'h0,
                 72'h05_0000000000000280, 72'h1C_0000000000000200, 1'b1};
    vecs[6]  = '{"rmw_0f",   1'b1, 8'h00, 8'h0F,
                 72'h00_AAAAAAAAAAAAAAAA, 72'h00_AAAAAAAAAAAAAAAA, 64'h5555555555555555,
                 72'h00_AAAAAAAA55555555, 72'h00_AAAAAAAA55555555, 1'b0};
    vecs[7]  = '{"full_0f",  1'b0, 8'h00, 8'h0F,
                 72'h00_AAAAAAAAAAAAAAAA, 72'h00_AAAAAAAAAAAAAAAA, 64'h5555555555555555,
                 72'h00_AAAAAAAAAAAAAAAA, 72'h00_AAAAAAAAAAAAAAAA, 1'b0};
    vecs[8]  = '{"rmw_m00",  1'b1, 8'h00, 8'h00, 72'h1, 72'h0, 64'h5555555555555555,
                 72'h07_0000000000000001, 72'h0, 1'b1};
    vecs[9]  = '{"rmw_mff",  1'b1, 8'h00, 8'hFF,
                 72'h00_AAAAAAAAAAAAAAAA, 72'h00_AAAAAAAAAAAAAAAA, 64'h3,
                 72'h0C_0000000000000003, 72'h0C_0000000000000003, 1'b1};
    vecs[10] = '{"raw_all",  1'b0, 8'hFF, 8'h00,
                 72'hC3_0123456789ABCDEF, 72'hC3_0123456789ABCDEF, 64'h0,
                 72'hC3_0123456789ABCDEF, 72'hC3_0123456789ABCDEF, 1'b1};
    vecs[11] = '{"raw_b0",   1'b0, 8'h01, 8'h00,
                 72'hC3_0000000000000001, 72'hC3_0000000000000001, 64'h0,
                 72'hC3_0000000000000001, 72'h07_0000000000000001, 1'b1};
    vecs[12] = '{"raw_rmw",  1'b1, 8'hFF, 8'h0F,
                 72'hC3_AAAAAAAAAAAAAAAA, 72'hC3_AAAAAAAAAAAAAAAA, 64'h5555555555555555,
                 72'hC3_AAAAAAAA55555555, 72'hC3_AAAAAAAA55555555, 1'b1};

    // reset state
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_en", 576'(enc_wr_data_en), 576'(0));
    chk("rst_data", enc_wr_data, 576'(0));
    chk("rst_pending", 576'(inj_pending), 576'(0));
    chk("rst_merge_cnt", 576'(merge_cnt), 576'(0));
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // one-shot injection across three back-to-back bursts
    inj_arm = 1'b1; inj_beat = 3'd2; inj_bit = 7'd5;
    tick();
    inj_arm = 1'b0;
    chk("inj_armed", 576'(inj_pending), 576'(1));
    wr_data_en = 1'b1;
    tick();
    tick();
    chk("inj_pending_t2", 576'(inj_pending), 576'(1));
    tick();
    wr_data_en = 1'b0;
    exp_bus = 576'h20 << 144;
    chk("inj_b1_en", 576'(enc_wr_data_en), 576'(1));
    chk("inj_b1_data", enc_wr_data, exp_bus);
    chk("inj_consumed", 576'(inj_pending), 576'(0));
    tick();
    chk("inj_b2_en", 576'(enc_wr_data_en), 576'(1));
    chk("inj_b2_data", enc_wr_data, 576'(0));
    tick();
    chk("inj_b3_en", 576'(enc_wr_data_en), 576'(1));
    chk("inj_b3_data", enc_wr_data, 576'(0));
    tick();
    chk("inj_b3_drop", 576'(enc_wr_data_en), 576'(0));

    // re-arm in the consuming cycle keeps the injector pending with the new selection
    inj_arm = 1'b1; inj_beat = 3'd7; inj_bit = 7'd71;
    tick();
    inj_arm = 1'b0;
    wr_data_en = 1'b1;
    tick();
    wr_data_en = 1'b0;
    tick();
    inj_arm = 1'b1; inj_beat = 3'd0; inj_bit = 7'd0;
    tick();
    inj_arm = 1'b0;
    exp_bus = 576'h1 << (7*72 + 71);
    chk("rearm_b1_data", enc_wr_data, exp_bus);
    chk("rearm_pending", 576'(inj_pending), 576'(1));
    wr_data_en = 1'b1;
    tick();
    wr_data_en = 1'b0;
    tick();
    tick();
    chk("rearm_b2_data", enc_wr_data, 576'(1));
    chk("rearm_consumed", 576'(inj_pending), 576'(0));

    // reset with two bursts in flight and the injector armed
    wr_data_en = 1'b1; wr_rmw = 1'b1; wr_data = 576'h1;
    tick();
    inj_arm = 1'b1; inj_beat = 3'd1; inj_bit = 7'd3;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    exp_mc = '0;
    tick();
    chk("mid_rst_en", 576'(enc_wr_data_en), 576'(0));
    chk("mid_rst_data", enc_wr_data, 576'(0));
    chk("mid_rst_pending", 576'(inj_pending), 576'(0));
    chk("mid_rst_merge_cnt", 576'(merge_cnt), 576'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 576'(enc_wr_data_en), 576'(0));
    end
    wr_data_en = 1'b1; wr_data = 576'h1;
    tick();
    idle_inputs();
    tick();
    chk("post_rst_early", 576'(enc_wr_data_en), 576'(0));
    tick();
    chk("post_rst_en", 576'(enc_wr_data_en), 576'(1));
    chk("post_rst_data", enc_wr_data, 576'h07_0000000000000001);

    // out-of-range bit index: consumed with nothing flipped
    inj_arm = 1'b1; inj_beat = 3'd3; inj_bit = 7'd100;
    tick();
    inj_arm = 1'b0;
    wr_data_en = 1'b1;
    tick();
    wr_data_en = 1'b0;
    tick();
    tick();
    chk("oor_data", enc_wr_data, 576'(0));
    chk("oor_consumed", 576'(inj_pending), 576'(0));

    // merge counter saturation
    wr_data_en = 1'b1; wr_rmw = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    wr_data_en = 1'b0;
    tick();
    chk("mc_fffe", 576'(merge_cnt), 576'(16'hFFFE));
    wr_data_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    wr_data_en = 1'b0; wr_rmw = 1'b0;
    tick();
    tick();
    chk("mc_sat", 576'(merge_cnt), 576'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
